instr_reader: RTL and testbench

// - Read-side sequencer for the instruction register: walks read_pointer over a

---
 rtl/instr_register_pkg.sv | 39 +++
 rtl/instr_result_model.sv | 61 ++++++
 rtl/instr_reader.sv | 96 +++++++++
 tb/tb_instr_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side sequencer.
// Operands are 32-bit signed; the result field is 64-bit signed and sign-extended from operand width.
package instr_register_pkg;

  localparam int OPER_W = 32;
  localparam int RES_W  = 64;
  localparam int ADDR_W = 5;

  typedef logic signed [OPER_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]  result_t;
  typedef logic [ADDR_W-1:0]        address_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/instr_result_model.sv
// Combinational golden model: expected result of one instruction word.
// Arithmetic is done at operand width, then sign-extended into the result field.
module instr_result_model
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  output result_t  exp_result,
  output logic     skip,
  output logic     bad_opc
);

  // Square-and-multiply; negative exponents follow integer-power rules (only |base|==1 survives).
  function automatic operand_t pow_op(input operand_t base, input operand_t e);
    operand_t acc;
    operand_t b;
    acc = operand_t'(1);
    b   = base;
    if (e < 0) begin
      if (base == operand_t'(1))       acc = operand_t'(1);
      else if (base == operand_t'(-1)) acc = e[0] ? operand_t'(-1) : operand_t'(1);
      else                             acc = '0;
    end else begin
      for (int i = 0; i < OPER_W - 1; i++) begin
        if (e[i]) acc = acc * b;
        b = b * b;
      end
    end
    return acc;
  endfunction

  operand_t r;

  always_comb begin
    r       = '0;
    skip    = 1'b0;
    bad_opc = 1'b0;
    case (opc)
      ZERO:  r = '0;
      PASSA: r = op_a;
      PASSB: r = op_b;
      ADD:   r = op_a + op_b;
      SUB:   r = op_a - op_b;
      MULT:  r = op_a * op_b;
      DIV: begin
        if (op_b == '0) skip = 1'b1;
        else            r = op_a / op_b;
      end
      MOD: begin
        if (op_b == '0) skip = 1'b1;
        else            r = op_a % op_b;
      end
      POW:   r = pow_op(op_a, op_b);
      default: bad_opc = 1'b1;
    endcase
  end

  assign exp_result = result_t'(r);

endmodule

// File: rtl/instr_reader.sv
// Read-side sequencer: walks read_pointer over a programmed window, streams each word
// on a valid/ready port and flags words whose stored result disagrees with the model.
module instr_reader
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  address_t           base_ptr,
  input  logic [CNT_W-1:0]   count,
  output address_t           read_pointer,
  input  instruction_t       instruction_word,
  output logic               out_valid,
  input  logic               out_ready,
  output instruction_t       out_instr,
  output address_t           out_index,
  output logic               mismatch,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count
);

  reader_state_t    state;
  logic [CNT_W-1:0] remaining;
  result_t          exp_result;
  logic             skip;
  logic             bad_opc;

  function automatic address_t next_ptr(input address_t p);
    return (p == address_t'(DEPTH - 1)) ? '0 : p + address_t'(1);
  endfunction

  instr_result_model u_model (
    .opc        (instruction_word.opc),
    .op_a       (instruction_word.op_a),
    .op_b       (instruction_word.op_b),
    .exp_result (exp_result),
    .skip       (skip),
    .bad_opc    (bad_opc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      read_pointer <= '0;
      remaining    <= '0;
      out_instr    <= '0;
      out_index    <= '0;
      out_valid    <= 1'b0;
      mismatch     <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            read_pointer <= base_ptr;
            remaining    <= count;
            err_count    <= '0;
            state        <= (count == '0) ? DONE : FETCH;
          end
        end
        // Capture stage: the word is sampled here only, so later register writes cannot leak in.
        FETCH: begin
          out_instr <= instruction_word;
          out_index <= read_pointer;
          mismatch  <= !skip && (bad_opc || (exp_result != instruction_word.result));
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        // Output stage: out_valid is always high here, so out_ready alone completes the handshake.
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (mismatch && (err_count != '1)) err_count <= err_count + CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end else begin
              read_pointer <= next_ptr(read_pointer);
              state        <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == FETCH) || (state == HOLD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_instr_reader.sv
// Directed bench for instr_reader: register array model behind read_pointer, hand-computed expectations.
module tb_instr_reader;
  import instr_register_pkg::*;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  address_t         base_ptr;
  logic [CNT_W-1:0] count;
  address_t         read_pointer;
  instruction_t     instruction_word;
  logic             out_valid;
  logic             out_ready;
  instruction_t     out_instr;
  address_t         out_index;
  logic             mismatch;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;

  instruction_t regs [32];
  assign instruction_word = regs[read_pointer];

  always #5 clk = ~clk;

  instr_reader #(.DEPTH(32), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_ptr         (base_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_index        (out_index),
    .mismatch         (mismatch),
    .busy             (busy),
    .done             (done),
    .err_count        (err_count)
  );

  int errors = 0;
  int checks = 0;

  int          nw, done_cnt, done_cyc, first_v;
  logic [63:0] idx_log [8];
  logic [63:0] mm_log  [8];
  logic [63:0] res_log [8];
  instruction_t held;
  int          bad_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b, input longint r);
    instruction_t w;
    w.opc    = o;
    w.op_a   = operand_t'(a);
    w.op_b   = operand_t'(b);
    w.result = result_t'(r);
    return w;
  endfunction

  task automatic launch(input int b, input int c);
    start    = 1'b1;
    base_ptr = address_t'(b);
    count    = CNT_W'(c);
    tick();
    start    = 1'b0;
  endtask

  // Samples max_cyc post-edge points (k=1 is just after the edge that took start); optional stray start at inject_k.
  task automatic run(input int max_cyc, input int inject_k);
    nw = 0; done_cnt = 0; done_cyc = -1; first_v = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && out_ready) begin
        if (nw < 8) begin
          idx_log[nw] = 64'(out_index);
          mm_log[nw]  = 64'(mismatch);
          res_log[nw] = out_instr.result;
        end
        nw++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      start = (k == inject_k);
      if (k == inject_k) begin
        base_ptr = address_t'(10);
        count    = CNT_W'(5);
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_ptr = '0; count = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = mk(ZERO, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_read_pointer", 64'(read_pointer), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_out_instr_result", out_instr.result, 64'd0);

    // Basic burst
    regs[0] = mk(PASSA, 5, 3, 5);
    regs[1] = mk(SUB, 9, 4, 5);
    regs[2] = mk(MULT, 6, 7, 42);
    out_ready = 1'b1;
    launch(0, 3);
    chk("basic_busy_after_start", 64'(busy), 64'd1);
    run(10, 0);
    chk("basic_words", 64'(nw), 64'd3);
    chk("basic_first_valid_latency", 64'(first_v), 64'd2);
    chk("basic_idx0", idx_log[0], 64'd0);
    chk("basic_idx1", idx_log[1], 64'd1);
    chk("basic_idx2", idx_log[2], 64'd2);
    chk("basic_res2", res_log[2], 64'd42);
    chk("basic_mm_any", mm_log[0] | mm_log[1] | mm_log[2], 64'd0);
    chk("basic_done_cycle", 64'(done_cyc), 64'd7);
    chk("basic_done_count", 64'(done_cnt), 64'd1);
    chk("basic_err_count", 64'(err_count), 64'd0);
    chk("basic_idle_busy", 64'(busy), 64'd0);

    // Backpressure: word 0 held 5 cycles, then accepted once; word 1 follows
    out_ready = 1'b0;
    launch(0, 2);
    tick();
    chk("bp_valid_first", 64'(out_valid), 64'd1);
    held = out_instr;
    regs[0] = mk(PASSA, 99, 3, 99);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_index_hold", 64'(out_index), 64'd0);
      checks++;
      assert (out_instr === held)
      else begin
        errors++;
        $error("FAIL bp_instr_hold observed=%0h expected=%0h", out_instr, held);
      end
    end
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    tick();
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_index", 64'(out_index), 64'd1);
    tick();
    chk("bp_done", 64'(done), 64'd1);
    tick();
    chk("bp_done_pulse_end", 64'(done), 64'd0);
    regs[0] = mk(PASSA, 5, 3, 5);

    // Wrap-around
    regs[30] = mk(ADD, 1, 2, 3);
    regs[31] = mk(PASSB, 4, 8, 8);
    launch(30, 4);
    run(14, 0);
    chk("wrap_words", 64'(nw), 64'd4);
    chk("wrap_idx0", idx_log[0], 64'd30);
    chk("wrap_idx1", idx_log[1], 64'd31);
    chk("wrap_idx2", idx_log[2], 64'd0);
    chk("wrap_idx3", idx_log[3], 64'd1);
    chk("wrap_done_count", 64'(done_cnt), 64'd1);
    chk("wrap_done_cycle", 64'(done_cyc), 64'd9);

    // Checker: wrong result, div-by-zero skip, bad opcode, pow, signed mod
    regs[5] = mk(ADD, 7, 3, 1);
    regs[6] = mk(DIV, 8, 0, 123);
    regs[7] = mk(opcode_t'(4'd12), 1, 1, 0);
    regs[8] = mk(POW, 2, 10, 1024);
    regs[9] = mk(MOD, -7, 3, -1);
    launch(5, 5);
    run(14, 0);
    chk("chk_words", 64'(nw), 64'd5);
    chk("chk_mm_add_wrong", mm_log[0], 64'd1);
    chk("chk_mm_div_zero", mm_log[1], 64'd0);
    chk("chk_mm_bad_opc", mm_log[2], 64'd1);
    chk("chk_mm_pow", mm_log[3], 64'd0);
    chk("chk_mm_mod_neg", mm_log[4], 64'd0);
    chk("chk_err_count", 64'(err_count), 64'd2);

    // Empty burst
    launch(3, 0);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_busy", 64'(busy), 64'd0);
    chk("empty_err_cleared", 64'(err_count), 64'd0);
    tick();
    chk("empty_done_pulse_end", 64'(done), 64'd0);

    // Start while busy is ignored
    launch(0, 1);
    run(12, 1);
    chk("busy_start_words", 64'(nw), 64'd1);
    chk("busy_start_idx", idx_log[0], 64'd0);
    chk("busy_start_done_count", 64'(done_cnt), 64'd1);
    chk("busy_start_done_cycle", 64'(done_cyc), 64'd3);

    // Reset mid-burst during HOLD
    out_ready = 1'b0;
    launch(4, 3);
    tick();
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_read_pointer", 64'(read_pointer), 64'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    bad_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) bad_done++;
      tick();
    end
    chk("rst_no_done", 64'(bad_done), 64'd0);
    chk("rst_idle_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
